// File: rtl/hgc_isa_vram_port_if.sv
// rtl/hgc_isa_vram_port_if.sv - ISA-side and VRAM-side signal bundle for the HGC CPU VRAM port
interface hgc_isa_vram_port_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  bus_memr;
    logic                  bus_memw;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_din;
    logic [DATA_WIDTH-1:0] bus_dout;
    logic                  bus_rdy;
    logic                  vram_sel;
    logic [ADDR_WIDTH-1:0] vram_addr;
    logic [DATA_WIDTH-1:0] vram_dout;
    logic                  vram_we;
    logic [DATA_WIDTH-1:0] vram_din;

    modport slave (
        input  bus_memr, bus_memw, bus_addr, bus_din, vram_din,
        output bus_dout, bus_rdy, vram_sel, vram_addr, vram_dout, vram_we
    );

    modport master (
        output bus_memr, bus_memw, bus_addr, bus_din, vram_din,
        input  bus_dout, bus_rdy, vram_sel, vram_addr, vram_dout, vram_we
    );
endinterface

// File: rtl/hgc_isa_vram_port.sv
// rtl/hgc_isa_vram_port.sv - latches ISA memory cycles and runs them as 3-cycle VRAM accesses inside sequencer grant windows
module hgc_isa_vram_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               isa_op_enable,
    output logic               busy,
    hgc_isa_vram_port_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_WIN = 3'd1,
        ACC1     = 3'd2,
        ACC2     = 3'd3,
        ACC3     = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t state, state_d;

    logic                  req;
    logic                  req_q;
    logic                  start;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  op_wr;

    logic                  rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] vaddr_q, vaddr_d;
    logic [DATA_WIDTH-1:0] vdout_q, vdout_d;
    logic                  busy_d;

    assign req   = bus.bus_memr | bus.bus_memw;
    assign start = req & ~req_q;

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        state_d = state;
        dout_d  = dout_q;
        vaddr_d = vaddr_q;
        vdout_d = vdout_q;

        case (state)
            IDLE:     if (start) state_d = WAIT_WIN;
            WAIT_WIN: if (isa_op_enable) state_d = ACC1;
            ACC1:     state_d = ACC2;
            ACC2: begin
                state_d = ACC3;
                if (!op_wr) dout_d = bus.vram_din;
            end
            // A strobe already gone by now means nobody is waiting on DONE.
            ACC3:     state_d = req_q ? DONE : IDLE;
            DONE:     if (!req_q) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (state == WAIT_WIN && state_d == ACC1) begin
            vaddr_d = addr_q;
            vdout_d = data_q;
        end

        sel_d  = (state_d == ACC1) || (state_d == ACC2) || (state_d == ACC3);
        we_d   = (state_d == ACC2) && op_wr;
        rdy_d  = (state_d == IDLE) || (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            op_wr   <= 1'b0;
            rdy_q   <= 1'b1;
            dout_q  <= '0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            vaddr_q <= '0;
            vdout_q <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            req_q   <= req;
            rdy_q   <= rdy_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            vaddr_q <= vaddr_d;
            vdout_q <= vdout_d;
            busy    <= busy_d;
            // Request fields are only sampled on a fresh edge seen from IDLE.
            if (state == IDLE && start) begin
                addr_q <= bus.bus_addr;
                data_q <= bus.bus_din;
                op_wr  <= bus.bus_memw;
            end
        end
    end

    assign bus.bus_rdy   = rdy_q;
    assign bus.bus_dout  = dout_q;
    assign bus.vram_sel  = sel_q;
    assign bus.vram_we   = we_q;
    assign bus.vram_addr = vaddr_q;
    assign bus.vram_dout = vdout_q;

endmodule

// File: tb/tb_hgc_isa_vram_port.sv
// tb/tb_hgc_isa_vram_port.sv - directed bench for hgc_isa_vram_port
module tb_hgc_isa_vram_port;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic en_man = 1'b0;
    logic seq_run = 1'b0;
    logic seq_en;
    logic isa_op_enable;
    logic [4:0] clkdiv = 5'd0;
    logic [4:0] clkdiv_nxt;
    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int sel_viol = 0;
    int sel_cycles = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] ref_mem [0:65535];

    hgc_isa_vram_port_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    hgc_isa_vram_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .isa_op_enable(isa_op_enable),
        .busy(busy),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Sequencer model: 18-cycle frame, grant raised one clock ahead so the
    // registered consumer owns VRAM during clkdiv 6..17 at most.
    assign clkdiv_nxt    = (clkdiv == 5'd17) ? 5'd0 : clkdiv + 5'd1;
    assign seq_en        = (clkdiv_nxt >= 5'd6) && (clkdiv_nxt <= 5'd15);
    assign isa_op_enable = seq_run ? seq_en : en_man;

    always @(posedge clk) begin
        clkdiv <= clkdiv_nxt;
        if (bus.vram_we) we_count <= we_count + 1;
        bus.vram_din <= mem[bus.vram_addr];
        if (bus.vram_we) mem[bus.vram_addr] = bus.vram_dout;
    end

    always @(negedge clk) begin
        if (seq_run && bus.vram_sel) begin
            sel_cycles <= sel_cycles + 1;
            if (clkdiv < 5'd6) sel_viol <= sel_viol + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_op(input bit wr, input logic [15:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output bit ok);
        bit idle_ok;
        bus.bus_addr = a;
        bus.bus_din  = d;
        bus.bus_memw = wr;
        bus.bus_memr = !wr;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (busy && bus.bus_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        rd = bus.bus_dout;
        bus.bus_memw = 1'b0;
        bus.bus_memr = 1'b0;
        wait_idle(idle_ok);
        ok = ok && idle_ok;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.bus_memr = 1'b0;
        bus.bus_memw = 1'b0;
        bus.bus_addr = '0;
        bus.bus_din  = '0;
        repeat (3) tick();
        checks++;
        if ({bus.bus_rdy, bus.vram_sel, bus.vram_we, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/sel/we/busy=%b expected 1000",
                     {bus.bus_rdy, bus.vram_sel, bus.vram_we, busy});
        end
        checks++;
        if ({bus.bus_dout, bus.vram_addr, bus.vram_dout} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: dout/vaddr/vdout=%h expected 0",
                     {bus.bus_dout, bus.vram_addr, bus.vram_dout});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_open();
        int w0;
        bit ok;
        en_man = 1'b1;
        w0 = we_count;
        bus.bus_addr = 16'h1234;
        bus.bus_din  = 8'hA5;
        bus.bus_memw = 1'b1;
        tick();
        checks++;
        if (bus.bus_rdy !== 1'b0 || bus.vram_sel !== 1'b0) begin
            errors++;
            $display("FAIL wr_rdy_latency: rdy=%b sel=%b expected rdy=0 sel=0", bus.bus_rdy, bus.vram_sel);
        end
        tick();
        checks++;
        if ({bus.vram_sel, bus.vram_we, bus.vram_addr, bus.vram_dout} !== {2'b10, 16'h1234, 8'hA5}) begin
            errors++;
            $display("FAIL wr_acc1: sel=%b we=%b addr=%h data=%h expected 1 0 1234 a5",
                     bus.vram_sel, bus.vram_we, bus.vram_addr, bus.vram_dout);
        end
        tick();
        checks++;
        if ({bus.vram_sel, bus.vram_we, bus.vram_addr, bus.vram_dout} !== {2'b11, 16'h1234, 8'hA5}) begin
            errors++;
            $display("FAIL wr_acc2: sel=%b we=%b addr=%h data=%h expected 1 1 1234 a5",
                     bus.vram_sel, bus.vram_we, bus.vram_addr, bus.vram_dout);
        end
        tick();
        checks++;
        if ({bus.vram_sel, bus.vram_we, bus.bus_rdy} !== 3'b100) begin
            errors++;
            $display("FAIL wr_acc3: sel/we/rdy=%b expected 100", {bus.vram_sel, bus.vram_we, bus.bus_rdy});
        end
        tick();
        checks++;
        if ({bus.vram_sel, bus.bus_rdy, busy} !== 3'b011) begin
            errors++;
            $display("FAIL wr_done: sel/rdy/busy=%b expected 011", {bus.vram_sel, bus.bus_rdy, busy});
        end
        bus.bus_memw = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || we_count - w0 != 1 || mem[16'h1234] !== 8'hA5) begin
            errors++;
            $display("FAIL wr_result: idle=%0d pulses=%0d mem=%h expected 1 1 a5", ok, we_count - w0, mem[16'h1234]);
        end
    endtask

    task automatic test_read_closed();
        bit bad;
        bit ok;
        en_man = 1'b0;
        mem[16'h7FFF] = 8'h3C;
        ref_mem[16'h7FFF] = 8'h3C;
        bus.bus_addr = 16'h7FFF;
        bus.bus_memr = 1'b1;
        tick();
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.bus_rdy !== 1'b0 || bus.vram_sel !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rd_closed_wait: rdy/sel not held 0/0 while window closed, got %b%b", bus.bus_rdy, bus.vram_sel);
        end
        en_man = 1'b1;
        tick();
        checks++;
        if (bus.vram_sel !== 1'b1 || bus.vram_addr !== 16'h7FFF) begin
            errors++;
            $display("FAIL rd_first_enable: sel=%b addr=%h expected 1 7fff", bus.vram_sel, bus.vram_addr);
        end
        tick();
        tick();
        checks++;
        if (bus.bus_rdy !== 1'b0 || bus.vram_we !== 1'b0) begin
            errors++;
            $display("FAIL rd_acc3: rdy=%b we=%b expected 0 0", bus.bus_rdy, bus.vram_we);
        end
        tick();
        checks++;
        if (bus.bus_rdy !== 1'b1 || bus.bus_dout !== 8'h3C) begin
            errors++;
            $display("FAIL rd_data: rdy=%b dout=%h expected 1 3c", bus.bus_rdy, bus.bus_dout);
        end
        bus.bus_memr = 1'b0;
        en_man = 1'b0;
        wait_idle(ok);
        repeat (3) tick();
        checks++;
        if (!ok || bus.bus_dout !== 8'h3C) begin
            errors++;
            $display("FAIL rd_hold: idle=%0d dout=%h expected 1 3c", ok, bus.bus_dout);
        end
    endtask

    task automatic test_sequencer();
        logic [7:0] rd;
        logic [7:0] d;
        logic [15:0] a;
        bit wr;
        bit ok;
        bit bad;
        seq_run = 1'b1;
        for (int n = 0; n < 100; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 16'($urandom_range(0, 31));
            d  = 8'($urandom_range(0, 255));
            do_op(wr, a, d, rd, ok);
            if (wr) ref_mem[a] = d;
            checks++;
            if (!ok || (!wr && rd !== ref_mem[a])) begin
                errors++;
                $display("FAIL seq_op%0d: wr=%0d addr=%h ok=%0d dout=%h expected ok=1 data=%h",
                         n, wr, a, ok, rd, ref_mem[a]);
            end
        end
        seq_run = 1'b0;
        tick();
        checks++;
        if (sel_viol != 0 || sel_cycles == 0) begin
            errors++;
            $display("FAIL seq_sel_window: out-of-window sel cycles=%0d total=%0d expected 0 and >0", sel_viol, sel_cycles);
        end
        bad = 1'b0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL seq_scoreboard: vram contents differ from expected memory in 0..31");
        end
    endtask

    task automatic test_both_strobes();
        int w0;
        bit ok;
        en_man = 1'b1;
        w0 = we_count;
        bus.bus_addr = 16'h0001;
        bus.bus_din  = 8'h55;
        bus.bus_memw = 1'b1;
        bus.bus_memr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy && bus.bus_rdy) break;
        end
        bus.bus_memw = 1'b0;
        bus.bus_memr = 1'b0;
        wait_idle(ok);
        checks++;
        if (!ok || we_count - w0 != 1 || mem[16'h0001] !== 8'h55) begin
            errors++;
            $display("FAIL both_strobes: idle=%0d pulses=%0d mem=%h expected 1 1 55", ok, we_count - w0, mem[16'h0001]);
        end
        ref_mem[16'h0001] = 8'h55;
    endtask

    task automatic test_release_in_wait();
        int w0;
        bit ok;
        en_man = 1'b0;
        w0 = we_count;
        bus.bus_addr = 16'h0BEE;
        bus.bus_din  = 8'h77;
        bus.bus_memw = 1'b1;
        tick();
        bus.bus_memw = 1'b0;
        repeat (3) tick();
        en_man = 1'b1;
        repeat (3) tick();
        tick();
        checks++;
        if (busy !== 1'b0 || bus.bus_rdy !== 1'b1 || we_count - w0 != 1 || mem[16'h0BEE] !== 8'h77) begin
            errors++;
            $display("FAIL release_wait: busy=%b rdy=%b pulses=%0d mem=%h expected 0 1 1 77",
                     busy, bus.bus_rdy, we_count - w0, mem[16'h0BEE]);
        end
        w0 = we_count;
        bus.bus_addr = 16'h0C00;
        bus.bus_din  = 8'h12;
        bus.bus_memw = 1'b1;
        tick();
        tick();
        bus.bus_memw = 1'b0;
        tick();
        bus.bus_din  = 8'hEE;
        bus.bus_memw = 1'b1;
        tick();
        tick();
        bus.bus_memw = 1'b0;
        wait_idle(ok);
        repeat (6) tick();
        checks++;
        if (!ok || busy !== 1'b0 || we_count - w0 != 1 || mem[16'h0C00] !== 8'h12) begin
            errors++;
            $display("FAIL second_edge: idle=%0d busy=%b pulses=%0d mem=%h expected 1 0 1 12",
                     ok, busy, we_count - w0, mem[16'h0C00]);
        end
    endtask

    task automatic test_reset_mid();
        en_man = 1'b1;
        bus.bus_addr = 16'h2222;
        bus.bus_din  = 8'h99;
        bus.bus_memw = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.vram_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: we=%b expected 1 in acc2", bus.vram_we);
        end
        reset = 1'b1;
        bus.bus_memw = 1'b0;
        tick();
        checks++;
        if ({bus.vram_we, bus.vram_sel, bus.bus_rdy, busy} !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid: we/sel/rdy/busy=%b expected 0010",
                     {bus.vram_we, bus.vram_sel, bus.bus_rdy, busy});
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.vram_we, bus.vram_sel, busy} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_idle: we/sel/busy=%b expected 000", {bus.vram_we, bus.vram_sel, busy});
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i) ^ 8'(i >> 8);
            ref_mem[i] = 8'(i) ^ 8'(i >> 8);
        end
        bus.bus_memr = 1'b0;
        bus.bus_memw = 1'b0;
        bus.bus_addr = '0;
        bus.bus_din  = '0;
        test_reset();
        test_write_open();
        test_read_closed();
        test_both_strobes();
        test_release_in_wait();
        test_sequencer();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
